decoder_2_4_seq: RTL and testbench

- Registered, handshaked 2-to-4 decoder, the receive-side counterpart of the 4:2 encoder.
- Accepts a 2-bit code {a,b} (a = MSB) through a valid/ready handshake.
- Drives exactly one of d0..d3 high for a programmable number of enabled cycles, then forces one all-low gap cycle before it accepts the next code.
- Used to regenerate one-hot select/strobe lines from encoded values.

---
 rtl/decoder_2_4_seq_pkg.sv | 35 +++
 rtl/decoder_2_4_seq_comb.sv | 23 ++
 rtl/decoder_2_4_seq.sv | 133 +++++++++++++
 tb/tb_decoder_2_4_seq.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/decoder_2_4_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_2_4_seq_pkg
//  Purpose  : Shared state encoding and code constants for the registered
//             2-to-4 decoder and its encoder counterpart.
//  Revision : 1.0  initial release
// ============================================================================
package decoder_2_4_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [1:0] CODE_D0 = 2'b00;
    localparam logic [1:0] CODE_D1 = 2'b01;
    localparam logic [1:0] CODE_D2 = 2'b10;
    localparam logic [1:0] CODE_D3 = 2'b11;

    function automatic logic [3:0] code_to_onehot(input logic [1:0] code);
        logic [3:0] onehot;
        onehot = 4'b0000;
        case (code)
            CODE_D0: onehot = 4'b0001;
            CODE_D1: onehot = 4'b0010;
            CODE_D2: onehot = 4'b0100;
            CODE_D3: onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
        return onehot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_2_4_seq_comb.sv
`default_nettype none
// ============================================================================
//  Module   : dec_2_4_comb
//  Purpose  : Combinational 2-bit code to one-hot map; all-low when disabled.
//  Revision : 1.0  initial release
// ============================================================================
module dec_2_4_comb
    import decoder_2_4_seq_pkg::*;
(
    input  logic [1:0] i_code,
    input  logic       i_en,
    output logic [3:0] o_onehot
);

    always_comb begin
        o_onehot = 4'b0000;
        if (i_en) begin
            o_onehot = code_to_onehot(i_code);
        end
    end

endmodule
`default_nettype wire

// File: rtl/decoder_2_4_seq.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_2_4_seq
//  Purpose  : Handshaked, registered 2-to-4 decoder holding the selected
//             one-hot line for HOLD_CYCLES enabled cycles, then one gap cycle.
//  Revision : 1.0  initial release
// ============================================================================
module decoder_2_4_seq
    import decoder_2_4_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic a,
    input  logic b,
    input  logic en,
    output logic d0,
    output logic d1,
    output logic d2,
    output logic d3,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] C_HOLD_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > (2**CNT_W) - 1) begin : g_bad_hold
        $error("decoder_2_4_seq: HOLD_CYCLES must be in 1..2**CNT_W-1");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       code_q, code_d;
    logic [3:0]       dout_q, dout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             in_ready_q, in_ready_d;

    logic             w_accept;
    logic             w_show;
    logic [1:0]       w_dec_code;
    logic [3:0]       w_onehot;

    assign w_accept = in_valid && in_ready_q;

    // The accept cycle decodes straight from the pins; afterwards only the
    // latched code is used, so a/b activity during HOLD is invisible.
    assign w_dec_code = (state_q == IDLE) ? {a, b} : code_q;

    dec_2_4_comb u_dec (
        .i_code   (w_dec_code),
        .i_en     (w_show),
        .o_onehot (w_onehot)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        w_show  = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d = HOLD;
                    cnt_d   = C_HOLD_LOAD;
                    code_d  = {a, b};
                    w_show  = 1'b1;
                end
            end
            HOLD: begin
                // en low freezes the counter and blanks the outputs.
                if (en) begin
                    cnt_d = cnt_q - C_CNT_ONE;
                    if (cnt_q == C_CNT_ONE) begin
                        state_d = GAP;
                    end else begin
                        w_show = 1'b1;
                    end
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        dout_d     = w_onehot;
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == GAP);
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            code_q     <= '0;
            dout_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign d0       = dout_q[0];
    assign d1       = dout_q[1];
    assign d2       = dout_q[2];
    assign d3       = dout_q[3];
    assign busy     = busy_q;
    assign done     = done_q;
    assign in_ready = in_ready_q;

    a_onehot0 : assert property (@(posedge clk) $onehot0(dout_q));
    a_ready_busy : assert property (@(posedge clk) !(in_ready_q && busy_q));

endmodule
`default_nettype wire

// File: tb/tb_decoder_2_4_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_2_4_seq
//  Purpose  : Directed-vector bench for decoder_2_4_seq (HOLD=4 and HOLD=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_decoder_2_4_seq;

    logic clk = 1'b0;
    logic rst, in_valid, a, b, en;

    logic rdy4, d0_4, d1_4, d2_4, d3_4, busy4, done4;
    logic rdy1, d0_1, d1_1, d2_1, d3_1, busy1, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoder_2_4_seq #(.HOLD_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
        .a(a), .b(b), .en(en),
        .d0(d0_4), .d1(d1_4), .d2(d2_4), .d3(d3_4),
        .busy(busy4), .done(done4)
    );

    decoder_2_4_seq #(.HOLD_CYCLES(1), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .a(a), .b(b), .en(en),
        .d0(d0_1), .d1(d1_1), .d2(d2_1), .d3(d3_1),
        .busy(busy1), .done(done1)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic       iv;
        logic       a;
        logic       b;
        logic       en;
        logic [6:0] exp;  // {in_ready, d3, d2, d1, d0, busy, done}
    } vec_t;

    vec_t tbl[$];

    function automatic logic [6:0] ex(input logic r, input logic [3:0] d,
                                      input logic bz, input logic dn);
        return {r, d, bz, dn};
    endfunction

    function automatic vec_t mk(input string n, input logic r, input logic iv,
                                input logic ai, input logic bi, input logic e,
                                input logic [6:0] x);
        vec_t v;
        v.name = n; v.rst = r; v.iv = iv; v.a = ai; v.b = bi; v.en = e; v.exp = x;
        return v;
    endfunction

    // Drive one cycle of inputs, clock it, then compare the registered outputs.
    task automatic apply(input vec_t v, input bit use1);
        logic [6:0] got;
        rst = v.rst; in_valid = v.iv; a = v.a; b = v.b; en = v.en;
        @(posedge clk);
        #1;
        if (use1) got = {rdy1, d3_1, d2_1, d1_1, d0_1, busy1, done1};
        else      got = {rdy4, d3_4, d2_4, d1_4, d0_4, busy4, done4};
        checks++;
        if (got !== v.exp) begin
            errors++;
            $display("FAIL %s: got rdy=%b d3..d0=%b busy=%b done=%b, expected rdy=%b d3..d0=%b busy=%b done=%b",
                     v.name, got[6], got[5:2], got[1], got[0],
                     v.exp[6], v.exp[5:2], v.exp[1], v.exp[0]);
        end
    endtask

    localparam logic [6:0] X_IDLE = 7'b1_0000_0_0;
    localparam logic [6:0] X_GAP  = 7'b0_0000_1_1;
    localparam logic [6:0] X_PAUS = 7'b0_0000_1_0;

    initial begin
        logic [1:0] c, n;
        logic [3:0] oh;
        rst = 1'b1; in_valid = 1'b0; a = 1'b0; b = 1'b0; en = 1'b1;

        // Reset (with in_valid asserted, which reset must override) then idle.
        tbl.push_back(mk("reset_1",  1, 1, 1, 0, 1, X_IDLE));
        tbl.push_back(mk("reset_2",  1, 1, 1, 0, 1, X_IDLE));
        tbl.push_back(mk("idle",     0, 0, 0, 0, 1, X_IDLE));

        // Back-to-back sweep; the next code is held valid while not ready.
        for (int k = 0; k < 4; k++) begin
            c  = k[1:0];
            n  = c + 2'd1;
            oh = 4'b0001 << k;
            tbl.push_back(mk("sweep_accept", 0, 1, c[1], c[0], 1, ex(1'b0, oh, 1'b1, 1'b0)));
            for (int h = 1; h < 4; h++) begin
                tbl.push_back(mk("sweep_hold", 0, logic'(k < 3), n[1], n[0], 1,
                                 ex(1'b0, oh, 1'b1, 1'b0)));
            end
            tbl.push_back(mk("sweep_gap",  0, logic'(k < 3), n[1], n[0], 1, X_GAP));
            tbl.push_back(mk("sweep_idle", 0, logic'(k < 3), n[1], n[0], 1, X_IDLE));
        end
        tbl.push_back(mk("sweep_after", 0, 0, 0, 0, 1, X_IDLE));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b0);

        // Enable pause on code 10: high, high, 3 paused, high, high, gap.
        apply(mk("pause_accept", 0, 1, 1, 0, 1, 7'b0_0100_1_0), 1'b0);
        apply(mk("pause_hold2",  0, 0, 0, 0, 1, 7'b0_0100_1_0), 1'b0);
        apply(mk("pause_off1",   0, 0, 0, 0, 0, X_PAUS), 1'b0);
        apply(mk("pause_off2",   0, 0, 0, 0, 0, X_PAUS), 1'b0);
        apply(mk("pause_off3",   0, 0, 0, 0, 0, X_PAUS), 1'b0);
        apply(mk("pause_hold3",  0, 0, 0, 0, 1, 7'b0_0100_1_0), 1'b0);
        apply(mk("pause_hold4",  0, 0, 0, 0, 1, 7'b0_0100_1_0), 1'b0);
        apply(mk("pause_gap",    0, 0, 0, 0, 1, X_GAP), 1'b0);
        apply(mk("pause_idle",   0, 0, 0, 0, 1, X_IDLE), 1'b0);

        // Code 11 offered during HOLD of 01 must be ignored.
        apply(mk("ign_accept", 0, 1, 0, 1, 1, 7'b0_0010_1_0), 1'b0);
        apply(mk("ign_pulse1", 0, 1, 1, 1, 1, 7'b0_0010_1_0), 1'b0);
        apply(mk("ign_pulse2", 0, 1, 1, 1, 1, 7'b0_0010_1_0), 1'b0);
        apply(mk("ign_hold4",  0, 0, 1, 1, 1, 7'b0_0010_1_0), 1'b0);
        apply(mk("ign_gap",    0, 0, 1, 1, 1, X_GAP), 1'b0);
        apply(mk("ign_idle",   0, 0, 1, 1, 1, X_IDLE), 1'b0);
        apply(mk("ign_still",  0, 0, 1, 1, 1, X_IDLE), 1'b0);

        // Reset on the second hold cycle of code 11 aborts with no done.
        apply(mk("rst_accept", 0, 1, 1, 1, 1, 7'b0_1000_1_0), 1'b0);
        apply(mk("rst_hold2",  0, 0, 0, 0, 1, 7'b0_1000_1_0), 1'b0);
        apply(mk("rst_abort",  1, 0, 0, 0, 1, X_IDLE), 1'b0);
        apply(mk("rst_after1", 0, 0, 0, 0, 1, X_IDLE), 1'b0);
        apply(mk("rst_after2", 0, 0, 0, 0, 1, X_IDLE), 1'b0);
        apply(mk("rst_after3", 0, 0, 0, 0, 1, X_IDLE), 1'b0);

        // HOLD_CYCLES=1 instance: clean state, then single-cycle hold.
        apply(mk("min_reset",  1, 0, 0, 0, 1, X_IDLE), 1'b1);
        apply(mk("min_accept", 0, 1, 0, 0, 1, 7'b0_0001_1_0), 1'b1);
        apply(mk("min_gap",    0, 0, 0, 0, 1, X_GAP), 1'b1);
        apply(mk("min_idle",   0, 0, 0, 0, 1, X_IDLE), 1'b1);
        // Same with a paused hold cycle before the single enabled one.
        apply(mk("min2_accept", 0, 1, 1, 0, 1, 7'b0_0100_1_0), 1'b1);
        apply(mk("min2_pause",  0, 0, 0, 0, 0, X_PAUS), 1'b1);
        apply(mk("min2_gap",    0, 0, 0, 0, 1, X_GAP), 1'b1);
        apply(mk("min2_idle",   0, 0, 0, 0, 1, X_IDLE), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
